// File: rtl/legv8_cw_pkg.sv
// Shared definitions for the LEGv8 control unit: control-word field map, ALU codes,
// opcodes, FSM states and the instruction classifier.
package legv8_cw_pkg;

    localparam int CW_SB_LSB  = 0;
    localparam int CW_SA_LSB  = 5;
    localparam int CW_DA_LSB  = 10;
    localparam int CW_RW      = 15;
    localparam int CW_MW      = 16;
    localparam int CW_MDS_LSB = 17;
    localparam int CW_C0      = 19;
    localparam int CW_FS_LSB  = 20;
    localparam int CW_SL      = 25;
    localparam int CW_IL      = 26;
    localparam int CW_BS      = 27;
    localparam int CW_EN_PC   = 28;
    localparam int CW_PS_LSB  = 29;
    localparam int CW_DS_LSB  = 31;
    localparam int CW_AS      = 33;

    localparam logic [4:0] FS_AND    = 5'b00000;
    localparam logic [4:0] FS_ORR    = 5'b00100;
    localparam logic [4:0] FS_ADD    = 5'b01000;
    localparam logic [4:0] FS_SUB    = 5'b01001;
    localparam logic [4:0] FS_PASS_B = 5'b01100;

    localparam logic [1:0] PS_INC = 2'b01;
    localparam logic [1:0] PS_BR  = 2'b11;
    localparam logic [1:0] DS_MEM = 2'b11;
    localparam logic [1:0] DS_ALU = 2'b01;
    localparam logic [4:0] XZR    = 5'd31;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_EXEC2    = 3'd3,
        S_MEM      = 3'd4,
        S_MEM_DONE = 3'd5,
        S_HALT     = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_B, IMM_CB, IMM_D
    } imm_fmt_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_B, CLS_CB, CLS_LD, CLS_ST, CLS_BAD
    } instr_cls_t;

    function automatic instr_cls_t decode_cls(input logic [31:0] ir);
        if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
            ir[31:21] == OP_AND || ir[31:21] == OP_ORR)
            return CLS_R;
        else if (ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI)
            return CLS_I;
        else if (ir[31:21] == OP_LDUR)
            return CLS_LD;
        else if (ir[31:21] == OP_STUR)
            return CLS_ST;
        else if (ir[31:26] == OP_B)
            return CLS_B;
        else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ)
            return CLS_CB;
        else
            return CLS_BAD;
    endfunction

    function automatic logic [4:0] alu_fs(input logic [31:0] ir);
        if (ir[31:21] == OP_SUB || ir[31:22] == OP_SUBI)
            return FS_SUB;
        else if (ir[31:21] == OP_AND)
            return FS_AND;
        else if (ir[31:21] == OP_ORR)
            return FS_ORR;
        else
            return FS_ADD;
    endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Combinational immediate extractor: selects and extends the immediate field of ir
// according to the instruction format the FSM is about to execute.
module legv8_imm_gen
    import legv8_cw_pkg::*;
(
    input  logic [31:0] ir,
    input  imm_fmt_t    fmt,
    output logic [63:0] imm
);

    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[31:26], ir[4:0]};

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {52'b0, ir[21:10]};
            IMM_B:   imm = {{36{ir[25]}}, ir[25:0], 2'b00};
            IMM_CB:  imm = {{43{ir[23]}}, ir[23:5], 2'b00};
            IMM_D:   imm = {{55{ir[20]}}, ir[20:12]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 sequencer. Outputs are registered from the next state, so the
// control word and constant seen in a cycle always belong to the current state.
module legv8_control_unit
    import legv8_cw_pkg::*;
#(
    parameter int CW_W     = 34,
    parameter int MAX_WAIT = 15
)
(
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     ir,
    input  logic [4:0]      status,
    input  logic            mem_ready,
    output logic [CW_W-1:0] control_word,
    output logic [63:0]     constant,
    output logic            halted,
    output logic [2:0]      state_dbg
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t          state, next_state;
    logic [WW-1:0]   wait_cnt;
    logic            waiting;
    logic [CW_W-1:0] cw_n;
    imm_fmt_t        fmt_n;
    logic [63:0]     imm;
    instr_cls_t      cls;
    logic            timeout;
    logic            taken;
    logic [4:0]      rd, rn, rm;

    logic unused_inputs;
    assign unused_inputs = ^{status[4:2], status[0], ir[15:10]};

    assign cls     = decode_cls(ir);
    assign rd      = ir[4:0];
    assign rn      = ir[9:5];
    assign rm      = ir[20:16];
    assign timeout = (wait_cnt == WW'(MAX_WAIT));
    // Branch decision is taken from the live Z flag while the pass-B cycle runs and
    // is captured by the control-word register together with the cycle-2 word.
    assign taken   = (ir[31:24] == OP_CBNZ) ? ~status[1] : status[1];

    legv8_imm_gen u_imm_gen (
        .ir  (ir),
        .fmt (fmt_n),
        .imm (imm)
    );

    always_comb begin
        next_state = state;
        waiting    = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
                else begin
                    waiting = 1'b1;
                    if (timeout) next_state = S_FAULT;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_R, CLS_I, CLS_B, CLS_CB: next_state = S_EXEC;
                    CLS_LD, CLS_ST:              next_state = S_MEM;
                    default:                     next_state = S_HALT;
                endcase
            end
            S_EXEC:     next_state = (cls == CLS_CB) ? S_EXEC2 : S_FETCH;
            S_EXEC2:    next_state = S_FETCH;
            S_MEM: begin
                if (mem_ready) next_state = S_MEM_DONE;
                else begin
                    waiting = 1'b1;
                    if (timeout) next_state = S_FAULT;
                end
            end
            S_MEM_DONE: next_state = S_FETCH;
            default:    next_state = state;
        endcase
    end

    always_comb begin
        cw_n  = '0;
        fmt_n = IMM_NONE;
        case (next_state)
            S_FETCH: begin
                cw_n[CW_AS]             = 1'b1;
                cw_n[CW_DS_LSB +: 2]    = DS_MEM;
                cw_n[CW_IL]             = 1'b1;
            end
            S_EXEC: begin
                case (cls)
                    CLS_R, CLS_I: begin
                        cw_n[CW_SA_LSB +: 5] = rn;
                        cw_n[CW_SB_LSB +: 5] = rm;
                        cw_n[CW_DA_LSB +: 5] = rd;
                        cw_n[CW_RW]          = (rd != XZR);
                        cw_n[CW_FS_LSB +: 5] = alu_fs(ir);
                        cw_n[CW_C0]          = (alu_fs(ir) == FS_SUB);
                        cw_n[CW_SL]          = 1'b1;
                        cw_n[CW_EN_PC]       = 1'b1;
                        cw_n[CW_PS_LSB +: 2] = PS_INC;
                        cw_n[CW_BS]          = (cls == CLS_I);
                        fmt_n                = (cls == CLS_I) ? IMM_I : IMM_NONE;
                    end
                    CLS_B: begin
                        cw_n[CW_EN_PC]       = 1'b1;
                        cw_n[CW_PS_LSB +: 2] = PS_BR;
                        fmt_n                = IMM_B;
                    end
                    CLS_CB: begin
                        cw_n[CW_SB_LSB +: 5] = rd;
                        cw_n[CW_FS_LSB +: 5] = FS_PASS_B;
                        fmt_n                = IMM_CB;
                    end
                    default: cw_n = '0;
                endcase
            end
            S_EXEC2: begin
                cw_n[CW_EN_PC]       = 1'b1;
                cw_n[CW_PS_LSB +: 2] = taken ? PS_BR : PS_INC;
                fmt_n                = IMM_CB;
            end
            S_MEM: begin
                cw_n[CW_SA_LSB +: 5] = rn;
                cw_n[CW_BS]          = 1'b1;
                cw_n[CW_FS_LSB +: 5] = FS_ADD;
                fmt_n                = IMM_D;
                if (cls == CLS_LD) begin
                    cw_n[CW_DS_LSB +: 2] = DS_MEM;
                    cw_n[CW_RW]          = (rd != XZR);
                    cw_n[CW_DA_LSB +: 5] = rd;
                end else begin
                    cw_n[CW_MW]          = 1'b1;
                    cw_n[CW_SB_LSB +: 5] = rd;
                    cw_n[CW_DS_LSB +: 2] = DS_ALU;
                end
            end
            S_MEM_DONE: begin
                cw_n[CW_EN_PC]       = 1'b1;
                cw_n[CW_PS_LSB +: 2] = PS_INC;
            end
            default: cw_n = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            control_word <= '0;
            constant     <= '0;
            halted       <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            state        <= next_state;
            control_word <= cw_n;
            constant     <= imm;
            halted       <= (next_state == S_HALT) || (next_state == S_FAULT);
            wait_cnt     <= (waiting && next_state == state) ? wait_cnt + 1'b1 : '0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for legv8_control_unit: per-instruction vector table plus
// hand-written wait, timeout, halt and asynchronous-reset sequences.
module tb_legv8_control_unit;

    localparam int P_SB = 0,  P_SA = 5,  P_DA = 10, P_RW = 15, P_MW = 16;
    localparam int P_C0 = 19, P_FS = 20, P_SL = 25, P_IL = 26, P_BS = 27;
    localparam int P_EN = 28, P_PS = 29, P_DS = 31, P_AS = 33;

    logic        clock;
    logic        reset;
    logic [31:0] ir;
    logic [4:0]  status;
    logic        mem_ready;
    logic [33:0] control_word;
    logic [63:0] constant;
    logic        halted;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    legv8_control_unit dut (
        .clock        (clock),
        .reset        (reset),
        .ir           (ir),
        .status       (status),
        .mem_ready    (mem_ready),
        .control_word (control_word),
        .constant     (constant),
        .halted       (halted),
        .state_dbg    (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir;
        logic        z;
        int          chk;
        logic [33:0] cw;
        logic        chk_k;
        logic [63:0] k;
        int          lat;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [33:0] fld(input int lsb, input int v);
        return 34'(v) << lsb;
    endfunction

    function automatic logic [33:0] rcw(input int sb, input int sa, input int da,
                                        input int rw, input int fs, input int c0,
                                        input int bs);
        return fld(P_SB, sb) | fld(P_SA, sa) | fld(P_DA, da) | fld(P_RW, rw) |
               fld(P_FS, fs) | fld(P_C0, c0) | fld(P_BS, bs) | fld(P_SL, 1) |
               fld(P_EN, 1) | fld(P_PS, 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [33:0] fetch_w;
        int n;
        fetch_w = fld(P_AS, 1) | fld(P_DS, 3) | fld(P_IL, 1);

        tbl[0]  = '{32'h910063E1, 1'b0, 2, rcw(0, 31, 1, 1, 8, 0, 1),  1'b1, 64'd24, 3};
        tbl[1]  = '{32'h8B020023, 1'b0, 2, rcw(2, 1, 3, 1, 8, 0, 0),   1'b0, 64'd0, 3};
        tbl[2]  = '{32'hCB0600A4, 1'b0, 2, rcw(6, 5, 4, 1, 9, 1, 0),   1'b0, 64'd0, 3};
        tbl[3]  = '{32'h8A090107, 1'b0, 2, rcw(9, 8, 7, 1, 0, 0, 0),   1'b0, 64'd0, 3};
        tbl[4]  = '{32'hAA02003F, 1'b0, 2, rcw(2, 1, 31, 0, 4, 0, 0),  1'b0, 64'd0, 3};
        tbl[5]  = '{32'hD13FFC62, 1'b0, 2, rcw(31, 3, 2, 1, 9, 1, 1),  1'b1, 64'd4095, 3};
        tbl[6]  = '{32'h17FFFFFF, 1'b0, 2, fld(P_EN, 1) | fld(P_PS, 3), 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 3};
        tbl[7]  = '{32'hB4000065, 1'b1, 3, fld(P_EN, 1) | fld(P_PS, 3), 1'b1, 64'd12, 4};
        tbl[8]  = '{32'hB4000065, 1'b0, 3, fld(P_EN, 1) | fld(P_PS, 1), 1'b0, 64'd0, 4};
        tbl[9]  = '{32'hB5FFFFE5, 1'b0, 3, fld(P_EN, 1) | fld(P_PS, 3), 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 4};
        tbl[10] = '{32'hB5FFFFE5, 1'b1, 3, fld(P_EN, 1) | fld(P_PS, 1), 1'b0, 64'd0, 4};
        tbl[11] = '{32'hF85F8149, 1'b0, 2, fld(P_SA, 10) | fld(P_BS, 1) | fld(P_FS, 8) |
                    fld(P_DS, 3) | fld(P_RW, 1) | fld(P_DA, 9), 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 4};
        tbl[12] = '{32'hF80FF083, 1'b0, 2, fld(P_SA, 4) | fld(P_SB, 3) | fld(P_MW, 1) |
                    fld(P_DS, 1) | fld(P_BS, 1) | fld(P_FS, 8), 1'b1, 64'd255, 4};
        tbl[13] = '{32'hF840003F, 1'b0, 2, fld(P_SA, 1) | fld(P_DA, 31) | fld(P_BS, 1) |
                    fld(P_FS, 8) | fld(P_DS, 3), 1'b1, 64'd0, 4};

        reset = 1'b0; ir = 32'h910063E1; status = '0; mem_ready = 1'b1;
        repeat (2) tick();
        check("rst_cw", 64'(control_word), 64'd0);
        check("rst_const", constant, 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            ir = tbl[i].ir;
            status = {3'b000, tbl[i].z, 1'b0};
            mem_ready = 1'b1;
            n = 0;
            do begin
                tick();
                n++;
                if (n == tbl[i].chk) begin
                    check($sformatf("vec%0d_cw", i), 64'(control_word), 64'(tbl[i].cw));
                    if (tbl[i].chk_k) check($sformatf("vec%0d_const", i), constant, tbl[i].k);
                end
            end while (state_dbg != 3'd0 && n < 8);
            check($sformatf("vec%0d_latency", i), 64'(n), 64'(tbl[i].lat));
            check($sformatf("vec%0d_fetch_cw", i), 64'(control_word), 64'(fetch_w));
        end

        // STUR with three wait cycles: MW held four cycles, then the PC+4 cycle
        ir = 32'hF80FF083; status = '0; mem_ready = 1'b1;
        tick();
        check("stw_decode", 64'(state_dbg), 64'd1);
        mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            mem_ready = (k == 4);
            check($sformatf("stw_mw%0d", k), 64'(control_word[P_MW]), 64'd1);
            check($sformatf("stw_state%0d", k), 64'(state_dbg), 64'd4);
        end
        tick();
        check("stw_pc_inc", 64'(control_word), 64'(fld(P_EN, 1) | fld(P_PS, 1)));
        tick();
        check("stw_back_fetch", 64'(state_dbg), 64'd0);

        // FETCH waits 15 cycles then handshakes: must not fault
        mem_ready = 1'b0;
        repeat (15) tick();
        check("fetch_wait15_state", 64'(state_dbg), 64'd0);
        check("fetch_wait15_il", 64'(control_word), 64'(fetch_w));
        mem_ready = 1'b1;
        tick();
        check("fetch_wait15_decode", 64'(state_dbg), 64'd1);

        // MEM with 16 wait cycles: FAULT
        mem_ready = 1'b0;
        tick();
        check("mem_to_state", 64'(state_dbg), 64'd4);
        repeat (15) tick();
        check("mem_wait16_still_mem", 64'(state_dbg), 64'd4);
        tick();
        check("fault_state", 64'(state_dbg), 64'd7);
        check("fault_halted", 64'(halted), 64'd1);
        check("fault_cw", 64'(control_word), 64'd0);
        mem_ready = 1'b1;
        repeat (3) tick();
        check("fault_sticky", 64'(state_dbg), 64'd7);
        do_reset();
        check("fault_reset_state", 64'(state_dbg), 64'd0);
        check("fault_reset_halted", 64'(halted), 64'd0);
        tick();

        // Undefined opcode: HALT held regardless of mem_ready
        ir = 32'hFFFFFFFF;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("halt_state%0d", k), 64'(state_dbg), 64'd6);
            check($sformatf("halt_cw%0d", k), 64'(control_word), 64'd0);
            check($sformatf("halt_halted%0d", k), 64'(halted), 64'd1);
            mem_ready = k[0];
            tick();
        end
        do_reset();
        mem_ready = 1'b1;
        tick();

        // Asynchronous reset in the middle of a STUR memory phase
        ir = 32'hF80FF083;
        tick();
        mem_ready = 1'b0;
        tick();
        check("arst_pre_mw", 64'(control_word[P_MW]), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        check("arst_cw", 64'(control_word), 64'd0);
        check("arst_state", 64'(state_dbg), 64'd0);
        check("arst_halted", 64'(halted), 64'd0);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        check("arst_release_state", 64'(state_dbg), 64'd0);
        tick();
        check("arst_next_decode", 64'(state_dbg), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
